fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to MAX_BURST beats, then drives that producer's data onto the FIFO's w_en/data_in.
- It sits directly in front of the FIFO write side, and FIFO full back-pressures the granted producer.

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write port
// among NUM_REQ valid/ready producers. A grant lasts up to MAX_BURST beats and
// ends early when the owner drops valid. FIFO full stalls the owner in place.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_owner, w_owner_next;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;

    // Candidate index at each priority position, rotated so position 0 is rr_ptr.
    logic [IDX_W-1:0]      w_cand [NUM_REQ];
    logic [NUM_REQ-1:0]    w_hit;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic [IDX_W-1:0]      w_pick;
    logic                  w_burst;
    logic                  w_owner_valid;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic [IDX_W-1:0]      w_owner_inc;

    assign w_burst = (r_state == ST_BURST);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        // rr_ptr + gi never exceeds 2*NUM_REQ-2, so one conditional subtract wraps it.
        logic [IDX_W:0] w_sum;
        assign w_sum       = {1'b0, r_rr_ptr} + (IDX_W + 1)'(gi);
        assign w_cand[gi]  = (w_sum >= (IDX_W + 1)'(NUM_REQ))
                           ? IDX_W'(w_sum - (IDX_W + 1)'(NUM_REQ))
                           : w_sum[IDX_W-1:0];
        assign w_hit[gi]   = req_valid[w_cand[gi]];
        assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        // Only the owner may see ready, and only while the FIFO can take a word.
        assign req_ready[gi] = w_burst & ~fifo_full & (r_owner == IDX_W'(gi));
    end

    // Pick the lowest priority position holding a valid requester.
    always_comb begin
        w_pick = w_cand[0];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_pick = w_cand[k];
            end
        end
    end

    assign w_owner_valid = req_valid[r_owner];
    assign w_xfer        = w_burst & w_owner_valid & ~fifo_full;
    assign w_last_beat   = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_owner_inc   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    // Next-state logic and FIFO write outputs.
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_rr_ptr_next   = r_rr_ptr;
        w_beat_cnt_next = r_beat_cnt;
        fifo_w_en       = 1'b0;
        fifo_data_in    = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_owner_next    = w_pick;
                    w_beat_cnt_next = '0;
                    w_state_next    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_owner_valid) begin
                    // Owner released early: hand priority to the next index.
                    w_state_next    = ST_IDLE;
                    w_rr_ptr_next   = w_owner_inc;
                    w_beat_cnt_next = '0;
                end else if (w_xfer) begin
                    fifo_w_en    = 1'b1;
                    fifo_data_in = w_slice[r_owner];
                    if (w_last_beat) begin
                        w_state_next    = ST_IDLE;
                        w_rr_ptr_next   = w_owner_inc;
                        w_beat_cnt_next = '0;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
                    end
                end
                // Otherwise FIFO full with owner valid: hold everything.
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign grant_id = r_owner;
    assign busy     = w_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (4 requesters / burst 4, and
// 3 requesters / burst 1) checked every cycle against a transaction-level model.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: NUM_REQ=4, MAX_BURST=4
    logic [3:0]  v4 = '0;
    logic [31:0] d4 = '0;
    logic        f4 = 1'b0;
    logic [3:0]  rdy4;
    logic        wen4;
    logic [7:0]  din4;
    logic [1:0]  gnt4;
    logic        busy4;

    // Instance B: NUM_REQ=3, MAX_BURST=1
    logic [2:0]  v3 = '0;
    logic [23:0] d3 = '0;
    logic        f3 = 1'b0;
    logic [2:0]  rdy3;
    logic        wen3;
    logic [7:0]  din3;
    logic [1:0]  gnt3;
    logic        busy3;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_data(d4), .req_ready(rdy4),
        .fifo_full(f4), .fifo_w_en(wen4), .fifo_data_in(din4),
        .grant_id(gnt4), .busy(busy4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
        .fifo_full(f3), .fifo_w_en(wen3), .fifo_data_in(din3),
        .grant_id(gnt3), .busy(busy3)
    );

    int checks   = 0;
    int failures = 0;

    // Abstract arbiter model: who holds the grant, how many beats it has moved,
    // and where the next round-robin search starts.
    typedef struct {
        bit busy;
        int owner;
        int ptr;
        int beats;
    } model_t;

    model_t m4, m3;
    int     w4_cnt = 0;
    int     w3_cnt = 0;
    int     grants3[$];
    bit     prev_busy3 = 1'b0;

    function automatic model_t model_reset();
        model_t r;
        r.busy = 1'b0; r.owner = 0; r.ptr = 0; r.beats = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, int n, int mb, logic [3:0] v, bit f);
        model_t r;
        r = m;
        if (!m.busy) begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (m.ptr + k) % n;
                if (v[i]) begin
                    r.busy = 1'b1; r.owner = i; r.beats = 0;
                    break;
                end
            end
        end else if (!v[m.owner]) begin
            r.busy = 1'b0; r.ptr = (m.owner + 1) % n; r.beats = 0;
        end else if (!f) begin
            r.beats = m.beats + 1;
            if (r.beats == mb) begin
                r.busy = 1'b0; r.ptr = (m.owner + 1) % n; r.beats = 0;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one instance's outputs against the model for the current inputs.
    task automatic check_dut(input string nm, input model_t m, input logic [3:0] v,
                             input logic [31:0] d, input bit f,
                             input logic [3:0] rdy, input logic wen, input logic [7:0] din,
                             input logic [1:0] gnt, input logic bsy);
        logic [3:0]  e_rdy;
        logic        e_wen;
        logic [7:0]  e_din;
        logic [31:0] dd;
        dd    = d;
        e_rdy = (m.busy && !f) ? (4'b0001 << m.owner) : 4'b0000;
        e_wen = m.busy && v[m.owner] && !f;
        e_din = e_wen ? dd[m.owner*8 +: 8] : 8'h00;
        check({nm, ".busy"},  32'(bsy), 32'(m.busy));
        check({nm, ".grant"}, 32'(gnt), 32'(m.owner));
        check({nm, ".ready"}, 32'(rdy), 32'(e_rdy));
        check({nm, ".w_en"},  32'(wen), 32'(e_wen));
        check({nm, ".data"},  32'(din), 32'(e_din));
    endtask

    // One clock cycle: check both DUTs mid-cycle, then advance the models.
    task automatic tick();
        @(negedge clk);
        check_dut("A", m4, v4, d4, f4, rdy4, wen4, din4, gnt4, busy4);
        check_dut("B", m3, {1'b0, v3}, {8'h00, d3}, f3, {1'b0, rdy3}, wen3, din3, gnt3, busy3);
        if (wen4) w4_cnt++;
        if (wen3) w3_cnt++;
        if (busy3 && !prev_busy3) grants3.push_back(int'(gnt3));
        prev_busy3 = busy3;
        $display("cyc t=%0t rst=%0b A:v=%b f=%0b gnt=%0d wen=%0b din=%h  B:v=%b f=%0b gnt=%0d wen=%0b din=%h",
                 $time, rst, v4, f4, gnt4, wen4, din4, v3, f3, gnt3, wen3, din3);
        @(posedge clk);
        if (rst) begin
            m4 = model_reset();
            m3 = model_reset();
        end else begin
            m4 = model_step(m4, 4, 4, v4, f4);
            m3 = model_step(m3, 3, 1, {1'b0, v3}, f3);
        end
        #1;
        d4 = $urandom;
        d3 = 24'($urandom);
    endtask

    initial begin
        m4 = model_reset();
        m3 = model_reset();

        // Reset held with every valid asserted: all outputs stay low.
        v4 = 4'hF; v3 = 3'h7;
        #1;
        tick();
        tick();

        // Release reset; the round-robin window starts at the idle cycle.
        rst = 1'b0;
        v3 = 3'h0;
        w4_cnt = 0;
        tick();
        check("A.first_grant_busy", 32'(busy4), 32'd1);
        check("A.first_grant_id",   32'(gnt4),  32'd0);
        for (int c = 1; c < 20; c++) tick();
        check("A.rr_writes_20cyc", 32'(w4_cnt), 32'd16);

        // Quiet, then requester 2 alone for two beats and a drop.
        v4 = 4'h0;
        tick();
        w4_cnt = 0;
        v4 = 4'b0100;
        tick();
        tick();
        tick();
        v4 = 4'h0;
        tick();
        check("A.early_writes", 32'(w4_cnt), 32'd2);
        check("A.early_idle",   32'(busy4),  32'd0);

        // Lone request from requester 1, then back-pressure after beat 1.
        w4_cnt = 0;
        v4 = 4'b0010;
        tick();
        check("A.lone_req1_grant", 32'(gnt4), 32'd1);
        tick();
        f4 = 1'b1;
        tick(); tick(); tick();
        check("A.stall_writes", 32'(w4_cnt), 32'd1);
        f4 = 1'b0;
        tick(); tick(); tick();
        check("A.bp_total_writes", 32'(w4_cnt), 32'd4);
        check("A.bp_exit", 32'(busy4), 32'd0);

        // Async reset between edges after two beats of a burst.
        v4 = 4'hF;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("A.async_busy",  32'(busy4), 32'd0);
        check("A.async_wen",   32'(wen4),  32'd0);
        check("A.async_ready", 32'(rdy4),  32'd0);
        check("A.async_data",  32'(din4),  32'd0);
        check("A.async_grant", 32'(gnt4),  32'd0);
        m4 = model_reset();
        m3 = model_reset();
        tick();
        rst = 1'b0;
        tick();
        check("A.post_reset_grant", 32'(gnt4), 32'd0);
        v4 = 4'h0;
        tick(); tick(); tick(); tick(); tick();

        // Wrap on the three-requester instance: 0, then 2, then back to 0.
        grants3.delete();
        prev_busy3 = busy3;
        v3 = 3'b101;
        for (int c = 0; c < 6; c++) tick();
        check("B.wrap_num_grants", 32'(grants3.size()), 32'd3);
        if (grants3.size() == 3) begin
            check("B.wrap_g0", 32'(grants3[0]), 32'd0);
            check("B.wrap_g1", 32'(grants3[1]), 32'd2);
            check("B.wrap_g2", 32'(grants3[2]), 32'd0);
        end
        v3 = 3'b000;
        tick();

        // Randomized traffic with occasional back-pressure and resets.
        for (int c = 0; c < 400; c++) begin
            v4 = 4'($urandom_range(0, 15));
            v3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) v4 = 4'hF;
            f4 = ($urandom_range(0, 3) == 0);
            f3 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                m4 = model_reset();
                m3 = model_reset();
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
